// File: rtl/watchdog_monitor_mc.sv
// Multi-channel watchdog: per-channel activity-change kick detection, bark at half
// timeout, sticky bite at full timeout. Optional windowed mode: define WDT_WINDOW_EN.
module watchdog_monitor_mc #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [NUM_CH-1:0]            en,
    input  logic [NUM_CH*DATA_WIDTH-1:0] data_in,
    input  logic [CNT_WIDTH-1:0]         timeout_val,
    input  logic [NUM_CH-1:0]            clear,
    output logic [NUM_CH-1:0]            delta,
    output logic [NUM_CH-1:0]            bark,
    output logic [NUM_CH-1:0]            bite,
    output logic                         bite_any
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_BARK,
        ST_BITE
    } state_t;

    state_t                state_q [NUM_CH];
    state_t                state_d [NUM_CH];
    logic [CNT_WIDTH-1:0]  count_q [NUM_CH];
    logic [CNT_WIDTH-1:0]  count_d [NUM_CH];
    logic [CNT_WIDTH-1:0]  next_cnt [NUM_CH];
    logic [DATA_WIDTH-1:0] prev_q [NUM_CH];
    logic [DATA_WIDTH-1:0] prev_d [NUM_CH];
    logic [NUM_CH-1:0]     armed_q;
    logic [NUM_CH-1:0]     armed_d;
    logic [NUM_CH-1:0]     delta_q;
    logic [NUM_CH-1:0]     delta_d;
    logic [NUM_CH-1:0]     kick;
    logic                  bite_any_q;
    logic                  bite_any_d;
    logic [CNT_WIDTH-1:0]  half_tv;

    assign half_tv = timeout_val >> 1;

`ifdef WDT_WINDOW_EN
    logic [CNT_WIDTH-1:0] quarter_tv;
    assign quarter_tv = timeout_val >> 2;
`endif

    // armed_q marks that the previous edge was enabled, so the first sample never kicks.
    always_comb begin
        for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
            prev_d[ch]   = data_in[ch*DATA_WIDTH +: DATA_WIDTH];
            armed_d[ch]  = en[ch];
            kick[ch]     = en[ch] & armed_q[ch] &
                           (data_in[ch*DATA_WIDTH +: DATA_WIDTH] != prev_q[ch]);
            delta_d[ch]  = kick[ch];
            next_cnt[ch] = (count_q[ch] == '1) ? count_q[ch] : count_q[ch] + CNT_WIDTH'(1);
        end
    end

    always_comb begin
        for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
            state_d[ch] = state_q[ch];
            count_d[ch] = count_q[ch];

            if (!en[ch]) begin
                state_d[ch] = ST_IDLE;
                count_d[ch] = '0;
            end else if (clear[ch] || state_q[ch] == ST_IDLE) begin
                state_d[ch] = ST_ARMED;
                count_d[ch] = '0;
            end else if (state_q[ch] == ST_BITE) begin
                state_d[ch] = ST_BITE;
            end else if (kick[ch]) begin
`ifdef WDT_WINDOW_EN
                if (state_q[ch] == ST_ARMED && count_q[ch] < quarter_tv) begin
                    state_d[ch] = ST_BITE;
                end else begin
                    state_d[ch] = ST_ARMED;
                    count_d[ch] = '0;
                end
`else
                state_d[ch] = ST_ARMED;
                count_d[ch] = '0;
`endif
            end else if (timeout_val == '0) begin
                state_d[ch] = ST_ARMED;
                count_d[ch] = '0;
            end else begin
                count_d[ch] = next_cnt[ch];
                if (next_cnt[ch] >= timeout_val) begin
                    state_d[ch] = ST_BITE;
                end else if (next_cnt[ch] >= half_tv) begin
                    state_d[ch] = ST_BARK;
                end else begin
                    state_d[ch] = ST_ARMED;
                end
            end
        end
    end

    always_comb begin
        bark = '0;
        bite = '0;
        for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
            bark[ch] = (state_q[ch] == ST_BARK);
            bite[ch] = (state_q[ch] == ST_BITE);
        end
        bite_any_d = |bite;
    end

    assign delta    = delta_q;
    assign bite_any = bite_any_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
                state_q[ch] <= ST_IDLE;
                count_q[ch] <= '0;
                prev_q[ch]  <= '0;
            end
            armed_q    <= '0;
            delta_q    <= '0;
            bite_any_q <= 1'b0;
        end else begin
            for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
                state_q[ch] <= state_d[ch];
                count_q[ch] <= count_d[ch];
                prev_q[ch]  <= prev_d[ch];
            end
            armed_q    <= armed_d;
            delta_q    <= delta_d;
            bite_any_q <= bite_any_d;
        end
    end

endmodule

// File: tb/tb_watchdog_monitor_mc.sv
// Self-checking bench for watchdog_monitor_mc: directed vector table, hand-written
// corner sequences and randomized traffic against an arithmetic reference model.
module tb_watchdog_monitor_mc;

    localparam int NCH = 4;
    localparam int DW  = 32;
    localparam int CW  = 16;

`ifdef WDT_WINDOW_EN
    localparam bit WINDOW = 1'b1;
`else
    localparam bit WINDOW = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rstn;
    logic [NCH-1:0]    en;
    logic [NCH*DW-1:0] data_in;
    logic [CW-1:0]     timeout_val;
    logic [NCH-1:0]    clear;
    logic [NCH-1:0]    delta;
    logic [NCH-1:0]    bark;
    logic [NCH-1:0]    bite;
    logic              bite_any;

    int checks = 0;
    int errors = 0;

    watchdog_monitor_mc #(
        .DATA_WIDTH(DW),
        .NUM_CH    (NCH),
        .CNT_WIDTH (CW)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .en         (en),
        .data_in    (data_in),
        .timeout_val(timeout_val),
        .clear      (clear),
        .delta      (delta),
        .bark       (bark),
        .bite       (bite),
        .bite_any   (bite_any)
    );

    always #5 clk = ~clk;

    // Reference model: idle count plus "enabled", "bitten" and "barking" flags per channel.
    bit          m_active  [NCH];
    bit          m_bitten  [NCH];
    bit          m_barking [NCH];
    int          m_cnt     [NCH];
    logic [DW-1:0] m_prev  [NCH];
    logic [NCH-1:0] m_delta;
    bit          m_bite_any;

    task automatic model_reset();
        for (int ch = 0; ch < NCH; ch++) begin
            m_active[ch]  = 0;
            m_bitten[ch]  = 0;
            m_barking[ch] = 0;
            m_cnt[ch]     = 0;
            m_prev[ch]    = '0;
        end
        m_delta    = '0;
        m_bite_any = 0;
    endtask

    task automatic model_edge();
        bit any;
        any = 0;
        for (int ch = 0; ch < NCH; ch++) any |= m_bitten[ch];
        m_bite_any = any;
        for (int ch = 0; ch < NCH; ch++) begin
            logic [DW-1:0] d;
            int  tv;
            bit  kick;
            int  n;
            d    = data_in[ch*DW +: DW];
            tv   = int'(timeout_val);
            kick = en[ch] && m_active[ch] && (d != m_prev[ch]);
            m_delta[ch] = kick;
            m_prev[ch]  = d;
            if (!en[ch]) begin
                m_active[ch] = 0; m_bitten[ch] = 0; m_barking[ch] = 0; m_cnt[ch] = 0;
            end else begin
                if (!m_active[ch] || clear[ch]) begin
                    m_bitten[ch] = 0; m_barking[ch] = 0; m_cnt[ch] = 0;
                end else if (m_bitten[ch]) begin
                    // sticky until clear / disable / reset
                end else if (kick) begin
                    if (WINDOW && !m_barking[ch] && m_cnt[ch] < tv / 4) begin
                        m_bitten[ch] = 1; m_barking[ch] = 0;
                    end else begin
                        m_cnt[ch] = 0; m_barking[ch] = 0;
                    end
                end else if (tv == 0) begin
                    m_cnt[ch] = 0; m_barking[ch] = 0;
                end else begin
                    n = (m_cnt[ch] + 1 > 65535) ? 65535 : m_cnt[ch] + 1;
                    m_cnt[ch] = n;
                    if (n >= tv) begin
                        m_bitten[ch] = 1; m_barking[ch] = 0;
                    end else begin
                        m_barking[ch] = (n >= tv / 2);
                    end
                end
                m_active[ch] = 1;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        logic [NCH-1:0] eb, et;
        for (int ch = 0; ch < NCH; ch++) begin
            eb[ch] = m_barking[ch];
            et[ch] = m_bitten[ch];
        end
        chk({tag, ".delta"},    32'(delta),    32'(m_delta));
        chk({tag, ".bark"},     32'(bark),     32'(eb));
        chk({tag, ".bite"},     32'(bite),     32'(et));
        chk({tag, ".bite_any"}, 32'(bite_any), 32'(m_bite_any));
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int ch, input logic [DW-1:0] v);
        data_in[ch*DW +: DW] = v;
    endtask

    typedef struct {
        logic        en0;
        logic        clr0;
        logic [31:0] d0;
        logic        dl;
        logic        bk;
        logic        bt;
        logic        ba;
    } vec_t;

    vec_t tbl [21];
    logic [CW-1:0] tv_choices [9];

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 32'd5,  1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 32'd5,  1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 32'd5,  1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 32'd5,  1'b0, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 32'd5,  1'b0, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 32'd5,  1'b0, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 32'd5,  1'b0, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 32'd5,  1'b0, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 32'd5,  1'b0, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 32'd5,  1'b0, 1'b0, 1'b1, 1'b1};
        tbl[10] = '{1'b1, 1'b0, 32'd6,  1'b1, 1'b0, 1'b1, 1'b1};
        tbl[11] = '{1'b1, 1'b1, 32'd6,  1'b0, 1'b0, 1'b0, 1'b1};
        tbl[12] = '{1'b1, 1'b0, 32'd6,  1'b0, 1'b0, 1'b0, 1'b0};
        tbl[13] = '{1'b1, 1'b0, 32'd6,  1'b0, 1'b0, 1'b0, 1'b0};
        tbl[14] = '{1'b1, 1'b0, 32'd6,  1'b0, 1'b0, 1'b0, 1'b0};
        tbl[15] = '{1'b1, 1'b0, 32'd6,  1'b0, 1'b1, 1'b0, 1'b0};
        tbl[16] = '{1'b1, 1'b0, 32'd7,  1'b1, 1'b0, 1'b0, 1'b0};
        tbl[17] = '{1'b1, 1'b0, 32'd7,  1'b0, 1'b0, 1'b0, 1'b0};
        tbl[18] = '{1'b0, 1'b0, 32'd7,  1'b0, 1'b0, 1'b0, 1'b0};
        tbl[19] = '{1'b1, 1'b0, 32'd9,  1'b0, 1'b0, 1'b0, 1'b0};
        tbl[20] = '{1'b1, 1'b0, 32'd10, 1'b1, 1'b0, WINDOW, 1'b0};

        tv_choices = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd7, 16'd8, 16'd13, 16'd20};

        rstn        = 1'b0;
        en          = '0;
        clear       = '0;
        data_in     = '0;
        timeout_val = 16'd8;
        model_reset();

        #3;
        chk("reset.delta",    32'(delta),    32'd0);
        chk("reset.bark",     32'(bark),     32'd0);
        chk("reset.bite",     32'(bite),     32'd0);
        chk("reset.bite_any", 32'(bite_any), 32'd0);
        #9 rstn = 1'b1;
        step();

        // Directed table on channel 0, timeout 8
        for (int i = 0; i < 21; i++) begin
            en      = {3'b000, tbl[i].en0};
            clear   = {3'b000, tbl[i].clr0};
            set_data(0, tbl[i].d0);
            step();
            chk($sformatf("tbl%0d.delta", i),    32'(delta),    32'({3'b000, tbl[i].dl}));
            chk($sformatf("tbl%0d.bark", i),     32'(bark),     32'({3'b000, tbl[i].bk}));
            chk($sformatf("tbl%0d.bite", i),     32'(bite),     32'({3'b000, tbl[i].bt}));
            chk($sformatf("tbl%0d.bite_any", i), 32'(bite_any), 32'(tbl[i].ba));
        end
        clear = '0;

        // Kick on the edge where ch1 would reach the bark threshold
        en = '0; step();
        timeout_val = 16'd8;
        set_data(1, 32'h100);
        en = 4'b0010; step();
        for (int k = 0; k < 3; k++) step();
        set_data(1, 32'h101); step();
        chk("kick_at_half.delta1", 32'(delta[1]), 32'd1);
        chk("kick_at_half.bark1",  32'(bark[1]),  32'd0);
        for (int k = 0; k < 3; k++) step();
        chk("kick_at_half.bark_c3", 32'(bark[1]), 32'd0);
        step();
        chk("kick_at_half.bark_c4", 32'(bark[1]), 32'd1);
        chk_model("kick_at_half");

        // Early kick at count 2 and a legal kick at count 5 (timeout 16)
        en = '0; step();
        timeout_val = 16'd16;
        set_data(2, 32'h55);
        en = 4'b0100; step();
        step(); step();
        set_data(2, 32'h56); step();
        chk("window_c2.delta2", 32'(delta[2]), 32'd1);
        chk("window_c2.bite2",  32'(bite[2]),  32'(WINDOW));
        clear = 4'b0100; step();
        clear = '0;
        for (int k = 0; k < 5; k++) step();
        set_data(2, 32'h57); step();
        chk("window_c5.bite2", 32'(bite[2]), 32'd0);
        chk("window_c5.bark2", 32'(bark[2]), 32'd0);
        chk_model("window_c5");

        // Lowering timeout below the current count bites on the next edge
        en = '0; step();
        timeout_val = 16'd16;
        en = 4'b0001; step();
        for (int k = 0; k < 6; k++) step();
        chk("lower_tv.pre_bite0", 32'(bite[0]), 32'd0);
        timeout_val = 16'd4; step();
        chk("lower_tv.bite0", 32'(bite[0]), 32'd1);
        chk_model("lower_tv");

        // timeout_val = 0 disables barking and biting
        en = '0; step();
        timeout_val = 16'd0;
        en = 4'b0001; step();
        for (int k = 0; k < 20; k++) step();
        chk("tv_zero.bark", 32'(bark), 32'd0);
        chk("tv_zero.bite", 32'(bite), 32'd0);

        // Kicks every 3 cycles keep ch0 quiet
        en = '0; step();
        timeout_val = 16'd8;
        set_data(0, 32'd100);
        en = 4'b0001; step();
        for (int k = 0; k < 30; k++) begin
            if (k % 3 == 2) set_data(0, data_in[31:0] + 32'd1);
            step();
            chk_model($sformatf("periodic%0d", k));
            if (k % 3 == 2) chk($sformatf("periodic%0d.delta0", k), 32'(delta[0]), 32'd1);
        end

        // Asynchronous reset mid-cycle with channels in BARK/BITE
        en = '0; step();
        timeout_val = 16'd8;
        en = 4'b0001;
        for (int k = 0; k < 4; k++) step();
        en = 4'b1111;
        for (int k = 0; k < 6; k++) step();
        chk("pre_rst.bite0", 32'(bite[0]),   32'd1);
        chk("pre_rst.bark",  32'(bark[3:1]), 32'h7);
        #2 rstn = 1'b0;
        #1;
        chk("mid_rst.delta",    32'(delta),    32'd0);
        chk("mid_rst.bark",     32'(bark),     32'd0);
        chk("mid_rst.bite",     32'(bite),     32'd0);
        chk("mid_rst.bite_any", 32'(bite_any), 32'd0);
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
        for (int ch = 0; ch < NCH; ch++) set_data(ch, $urandom() | 32'h1);
        step();
        chk("post_rst.delta", 32'(delta), 32'd0);
        for (int ch = 0; ch < NCH; ch++) set_data(ch, ~data_in[ch*DW +: DW]);
        step();
        chk("post_rst.delta2", 32'(delta), 32'hF);
        chk_model("post_rst");

        // Randomized traffic against the model
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (cyc % 40 == 0) timeout_val = tv_choices[$urandom_range(0, 8)];
            if ($urandom_range(0, 7) == 0) en[$urandom_range(0, NCH-1)] ^= 1'b1;
            for (int ch = 0; ch < NCH; ch++) begin
                clear[ch] = ($urandom_range(0, 15) == 0);
                if ($urandom_range(0, 5) == 0) set_data(ch, $urandom());
            end
            step();
            chk_model($sformatf("rand%0d", cyc));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/watchdog_monitor_mc.md
Name: watchdog_monitor_mc

Overview:
Multi-channel, parametrised watchdog monitor and successor to the single-channel watchdog timer driver. Each channel watches a DATA_WIDTH-bit activity word and treats any change as a kick. Idle cycles are counted against a programmable timeout, with a two-stage warning: bark at half timeout, then a sticky bite at full timeout. Sits beside the system controller; bite_any feeds the reset/interrupt aggregator.

Parameters:
DATA_WIDTH, 32, width of each channel's activity word
NUM_CH, 4, number of independent watchdog channels (1..16)
CNT_WIDTH, 16, width of the idle counter and timeout value

Ports:
clk  input  1  system clock, rising-edge
rstn  input  1  asynchronous active-low reset
en  input  NUM_CH  per-channel enable; 0 forces channel to IDLE
data_in  input  NUM_CH*DATA_WIDTH  activity words; channel i = bits [i*DATA_WIDTH +: DATA_WIDTH]
timeout_val  input  CNT_WIDTH  shared timeout in cycles; 0 = timeouts disabled (count frozen at 0)
clear  input  NUM_CH  per-channel synchronous clear; releases a sticky bite
delta  output  NUM_CH  1-cycle registered pulse per detected change (kick)
bark  output  NUM_CH  high while channel is in BARK
bite  output  NUM_CH  high while channel is in BITE (sticky)
bite_any  output  1  registered OR of all bite bits

Behaviour:
- Reset (rstn=0, async): prev_q=0, count=0, state=IDLE, delta/bark/bite/bite_any=0 for all channels. Reset mid-operation discards all state immediately.
- Per channel, per edge: prev_q <= data_in[i] unconditionally. kick = en[i] & armed_prev & (data_in[i] != prev_q). armed_prev is set on the first enabled edge, so the first sample after enable never kicks.
- delta[i] <= kick. Latency: a change sampled at edge N gives delta high for cycle N..N+1.
- States: IDLE, ARMED, BARK, BITE. Priority per edge, highest first: en=0, clear, kick, threshold.
  - en=0: IDLE, count=0, armed_prev=0.
  - IDLE & en=1: go to ARMED, count=0.
  - clear=1 while enabled: go to ARMED, count=0. Clear beats a simultaneous kick or threshold.
  - kick in ARMED or BARK: go to ARMED, count=0. Kick beats a same-edge threshold. A kick in BITE is ignored; delta still pulses.
  - ARMED/BARK without kick: next=count+1, saturating at all-ones.
    - next >= timeout_val: go to BITE.
    - else next >= (timeout_val>>1): go to BARK.
    - else stay in ARMED.
  - BITE: count frozen; exits only on clear, en=0 or reset.
  - timeout_val=0: channel stays in ARMED with count=0 and never barks or bites.
- Outputs bark/bite are decoded from registered state. bite_any is registered one cycle after bite.
- timeout_val is compared live each cycle. Lowering it below the current count takes effect on the next edge (>= compare), with no missed match.
- Channels are fully independent; only timeout_val is shared.

Optional Feature:
- Macro WDT_WINDOW_EN.
- Defined: windowed watchdog. A kick while in ARMED with count < (timeout_val>>2) is an early kick and moves the channel to BITE instead of clearing the count. A kick at count >= (timeout_val>>2) behaves normally.
- Undefined: kicks are legal at any count; no early-kick check logic is synthesised.

Test Plan:
- Reset then en=4'b0001, timeout_val=8, data_in ch0 constant -> ch0 bark high from cycle 4 after the ARMED edge, bite high from cycle 8; bite_any one cycle later; channels 1-3 stay 0.
- Same setup, ch0 data increments every 3 cycles -> delta pulses every 3 cycles; bark and bite never assert; count never exceeds 3.
- ch0 in BITE, pulse clear for 1 cycle with data constant -> bite drops the following cycle and the bark/bite sequence restarts (bark at +4, bite at +8).
- ch1 enabled, kick arrives on the same edge count reaches 4 (timeout_val=8) -> channel stays in ARMED with count=0; bark not asserted.
- rstn pulled low while ch0-ch3 are in BARK/BITE, mid-cycle -> all outputs 0 immediately. After release with en held high, the first data sample produces no delta.
- With WDT_WINDOW_EN defined, timeout_val=16, ch2 kicks at count 2 -> bite[2]=1. Kick at count 5 -> stays ARMED. Without the macro, a kick at count 2 leaves bite[2]=0.
